// File: rtl/hsst_pkg.sv
// Shared HSST lane definitions: K codes, framer states and lane word builders.
// Used by the TX framer and the RX comma/frame parser.
package hsst_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned K_W    = 4;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned SEQ_W  = 8;
  localparam int unsigned CSUM_W = 24;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K28_0 = 8'h1C;

  localparam logic [K_W-1:0] K_LANE0 = 4'b0001;
  localparam logic [K_W-1:0] K_NONE  = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_EOF  = 3'd4,
    ST_IFG  = 3'd5,
    ST_DROP = 3'd6
  } tx_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [K_W-1:0]    k;
  } hsst_word_t;

  localparam hsst_word_t IDLE_WORD = '{data: {24'h0, K28_5}, k: K_LANE0};
  localparam hsst_word_t FILL_WORD = '{data: {24'h0, K28_0}, k: K_LANE0};
  localparam hsst_word_t PAD_WORD  = '{data: '0, k: K_NONE};

  function automatic hsst_word_t sof_word(input logic [LEN_W-1:0] len,
                                          input logic [SEQ_W-1:0] seq);
    sof_word = '{data: {len, seq, K27_7}, k: K_LANE0};
  endfunction

  function automatic hsst_word_t eof_word(input logic [CSUM_W-1:0] csum);
    eof_word = '{data: {csum, K29_7}, k: K_LANE0};
  endfunction

endpackage

// File: rtl/hsst_tx_framer.sv
// HSST TX framer: wraps a valid/ready word stream into comma/SOF/payload/EOF
// lane words with every K character in byte lane 0.
module hsst_tx_framer
  import hsst_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned IFG_MIN = 4
) (
  input  logic              tx_clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [LEN_W-1:0]  s_len,
  output logic [DATA_W-1:0] hsst_txd,
  output logic [K_W-1:0]    hsst_txk,
  output logic              frame_done,
  output logic              len_err
);

  localparam int unsigned IFG_W    = (IFG_MIN < 1) ? 1 : $clog2(IFG_MIN + 1);
  localparam int unsigned IFG_LAST = (IFG_MIN == 0) ? 0 : IFG_MIN - 1;

  tx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [IFG_W-1:0]  ifg_cnt_q, ifg_cnt_d;
  logic              drop_q, drop_d;
  hsst_word_t        out_q, out_d;
  logic              frame_done_q, frame_done_d;
  logic              len_err_q, len_err_d;
  logic              len_ok;
  logic              last_slot;

  assign s_ready   = (state_q == ST_DATA) || (state_q == ST_DROP);
  assign len_ok    = (s_len != '0) && (s_len <= LEN_W'(MAX_LEN));
  assign last_slot = (cnt_q == len_q - LEN_W'(1));

  // Next-state and next-output word; the chosen word is driven one clock later.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    csum_d       = csum_q;
    seq_d        = seq_q;
    ifg_cnt_d    = ifg_cnt_q;
    drop_d       = drop_q;
    out_d        = IDLE_WORD;
    frame_done_d = 1'b0;
    len_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid && (ifg_cnt_q >= IFG_W'(IFG_MIN))) begin
          if (len_ok) begin
            len_d   = s_len;
            cnt_d   = '0;
            csum_d  = '0;
            drop_d  = 1'b0;
            state_d = ST_SOF;
          end else begin
            len_err_d = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end
      ST_SOF: begin
        out_d   = sof_word(len_q, seq_q);
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (s_valid) begin
          out_d  = '{data: s_data, k: K_NONE};
          csum_d = csum_q + s_data;
          cnt_d  = cnt_q + LEN_W'(1);
          if (last_slot) begin
            if (!s_last) begin
              len_err_d = 1'b1;
              drop_d    = 1'b1;
            end
            state_d = ST_EOF;
          end else if (s_last) begin
            len_err_d = 1'b1;
            state_d   = ST_PAD;
          end
        end else begin
          // Starved mid-frame: keep the lane busy with a K filler.
          out_d = FILL_WORD;
        end
      end
      ST_PAD: begin
        out_d = PAD_WORD;
        cnt_d = cnt_q + LEN_W'(1);
        if (last_slot) state_d = ST_EOF;
      end
      ST_EOF: begin
        out_d        = eof_word(csum_q[CSUM_W-1:0]);
        frame_done_d = 1'b1;
        seq_d        = seq_q + SEQ_W'(1);
        ifg_cnt_d    = '0;
        drop_d       = 1'b0;
        if (drop_q)            state_d = ST_DROP;
        else if (IFG_MIN == 0) state_d = ST_IDLE;
        else                   state_d = ST_IFG;
      end
      ST_IFG: begin
        if (ifg_cnt_q < IFG_W'(IFG_MIN)) ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
        if (ifg_cnt_q >= IFG_W'(IFG_LAST)) state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (s_valid && s_last) begin
          ifg_cnt_d = '0;
          state_d   = (IFG_MIN == 0) ? ST_IDLE : ST_IFG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      seq_q        <= '0;
      ifg_cnt_q    <= IFG_W'(IFG_MIN);
      drop_q       <= 1'b0;
      out_q        <= IDLE_WORD;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      seq_q        <= seq_d;
      ifg_cnt_q    <= ifg_cnt_d;
      drop_q       <= drop_d;
      out_q        <= out_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
    end
  end

  assign hsst_txd   = out_q.data;
  assign hsst_txk   = out_q.k;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_hsst_tx_framer.sv
// Scoreboard bench for hsst_tx_framer: directed frames push expected non-idle
// lane words; a monitor pops and compares every non-comma output cycle.
module tb_hsst_tx_framer;

  logic        tx_clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [15:0] s_len;
  logic [31:0] hsst_txd;
  logic [3:0]  hsst_txk;
  logic        frame_done;
  logic        len_err;

  always #5 tx_clk = ~tx_clk;

  hsst_tx_framer #(.MAX_LEN(1024), .IFG_MIN(4)) dut (
    .tx_clk     (tx_clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_len      (s_len),
    .hsst_txd   (hsst_txd),
    .hsst_txk   (hsst_txk),
    .frame_done (frame_done),
    .len_err    (len_err)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        fd;
    logic        le;
  } obs_t;

  localparam obs_t COMMA = '{d: 32'h000000BC, k: 4'b0001, fd: 1'b0, le: 1'b0};

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   gap   = 100;
  logic chk_idle  = 1'b0;
  logic final_chk = 1'b0;
  logic done      = 1'b0;

  function automatic void push(input logic [31:0] d, input logic [3:0] k,
                               input logic fd, input logic le);
    obs_t e;
    e = '{d: d, k: k, fd: fd, le: le};
    exp_q.push_back(e);
  endfunction

  // Monitor: all comparisons live here so one process owns the counters.
  always begin : monitor
    obs_t obs;
    obs_t e;
    @(negedge tx_clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      obs = '{d: hsst_txd, k: hsst_txk, fd: frame_done, le: len_err};
      total++;
      if (obs !== COMMA) begin
        bad++;
        $display("FAIL reset_comma: got txd=%h k=%b fd=%b le=%b, want 000000bc 0001 0 0",
                 obs.d, obs.k, obs.fd, obs.le);
      end
      gap = 100;
    end else begin
      obs = '{d: hsst_txd, k: hsst_txk, fd: frame_done, le: len_err};
      if (chk_idle) begin
        total++;
        if (obs !== COMMA) begin
          bad++;
          $display("FAIL idle_comma: got txd=%h k=%b fd=%b le=%b, want 000000bc 0001 0 0",
                   obs.d, obs.k, obs.fd, obs.le);
        end
      end
      if (obs !== COMMA) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got txd=%h k=%b fd=%b le=%b, want nothing",
                   obs.d, obs.k, obs.fd, obs.le);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL lane_word: got txd=%h k=%b fd=%b le=%b, want txd=%h k=%b fd=%b le=%b",
                     obs.d, obs.k, obs.fd, obs.le, e.d, e.k, e.fd, e.le);
          end
        end
        if (obs.k == 4'b0001 && obs.d[7:0] == 8'hFB) begin
          total++;
          if (gap < 4) begin
            bad++;
            $display("FAIL ifg_gap: got %0d commas before SOF, want >= 4", gap);
          end
        end
        if (obs.fd) gap = 0;
      end else begin
        gap++;
      end
      if (final_chk && !done) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL drain: got %0d words still expected, want 0", exp_q.size());
        end
        done = 1'b1;
      end
    end
  end

  task automatic beat(input logic [31:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge tx_clk);
      if (s_ready) begin
        @(posedge tx_clk);
        #1;
        s_valid = 1'b0;
        return;
      end
    end
    $display("FAIL beat_timeout: got no s_ready for data %h, want accept within 200 cycles", d);
    $fatal(1);
  endtask

  initial begin : stim
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_len   = '0;
    repeat (3) @(negedge tx_clk);
    rst_n    = 1'b1;
    chk_idle = 1'b1;
    repeat (8) @(negedge tx_clk);
    chk_idle = 1'b0;
    @(posedge tx_clk);
    #1;

    // Back-to-back 3-word frame, seq 0.
    s_len = 16'd3;
    push(32'h000300FB, 4'b0001, 1'b0, 1'b0);
    push(32'd1, 4'b0000, 1'b0, 1'b0);
    push(32'd2, 4'b0000, 1'b0, 1'b0);
    push(32'd3, 4'b0000, 1'b0, 1'b0);
    push(32'h000006FD, 4'b0001, 1'b1, 1'b0);
    beat(32'd1, 1'b0);
    beat(32'd2, 1'b0);
    beat(32'd3, 1'b1);

    // Two-cycle starvation mid-frame produces two fillers, seq 1.
    s_len = 16'd4;
    push(32'h000401FB, 4'b0001, 1'b0, 1'b0);
    push(32'h11111111, 4'b0000, 1'b0, 1'b0);
    push(32'h22222222, 4'b0000, 1'b0, 1'b0);
    push(32'h0000001C, 4'b0001, 1'b0, 1'b0);
    push(32'h0000001C, 4'b0001, 1'b0, 1'b0);
    push(32'h33333333, 4'b0000, 1'b0, 1'b0);
    push(32'h44444444, 4'b0000, 1'b0, 1'b0);
    push(32'hAAAAAAFD, 4'b0001, 1'b1, 1'b0);
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b0);
    repeat (2) @(posedge tx_clk);
    #1;
    beat(32'h33333333, 1'b0);
    beat(32'h44444444, 1'b1);

    // Early s_last: padded with two zero words, checksum truncated to 24 bits.
    s_len = 16'd4;
    push(32'h000402FB, 4'b0001, 1'b0, 1'b0);
    push(32'h01000005, 4'b0000, 1'b0, 1'b0);
    push(32'h02000007, 4'b0000, 1'b0, 1'b1);
    push(32'h00000000, 4'b0000, 1'b0, 1'b0);
    push(32'h00000000, 4'b0000, 1'b0, 1'b0);
    push(32'h00000CFD, 4'b0001, 1'b1, 1'b0);
    beat(32'h01000005, 1'b0);
    beat(32'h02000007, 1'b1);

    // Overrun: EOF after word 2, words 3-4 dropped behind commas.
    s_len = 16'd2;
    push(32'h000203FB, 4'b0001, 1'b0, 1'b0);
    push(32'd5, 4'b0000, 1'b0, 1'b0);
    push(32'd6, 4'b0000, 1'b0, 1'b1);
    push(32'h00000BFD, 4'b0001, 1'b1, 1'b0);
    beat(32'd5, 1'b0);
    beat(32'd6, 1'b0);
    beat(32'd7, 1'b0);
    beat(32'd8, 1'b1);

    // Illegal lengths 0 and MAX_LEN+1 are rejected without consuming a seq.
    s_len = 16'd0;
    push(32'h000000BC, 4'b0001, 1'b0, 1'b1);
    beat(32'hDEAD0000, 1'b1);
    s_len = 16'd1025;
    push(32'h000000BC, 4'b0001, 1'b0, 1'b1);
    beat(32'hDEAD0001, 1'b1);

    // 256 one-word frames from seq 4: seq wraps 0xFF -> 0x00.
    for (int i = 0; i < 256; i++) begin
      logic [7:0]  sq;
      logic [31:0] w;
      sq = 8'(4 + i);
      w  = 32'(i + 100);
      s_len = 16'd1;
      push({16'd1, sq, 8'hFB}, 4'b0001, 1'b0, 1'b0);
      push(w, 4'b0000, 1'b0, 1'b0);
      push({w[23:0], 8'hFD}, 4'b0001, 1'b1, 1'b0);
      beat(w, 1'b1);
    end

    // Reset mid-DATA: the accepted word never reaches a sampling edge.
    s_len = 16'd5;
    push(32'h000504FB, 4'b0001, 1'b0, 1'b0);
    beat(32'h0BADF00D, 1'b0);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge tx_clk);
    rst_n    = 1'b1;
    chk_idle = 1'b1;
    repeat (6) @(negedge tx_clk);
    chk_idle  = 1'b0;
    final_chk = 1'b1;
    for (int i = 0; i < 50 && !done; i++) @(negedge tx_clk);
    if (!done) begin
      $display("FAIL final_timeout: got no drain check, want one within 50 cycles");
      $fatal(1);
    end
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
